// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 2-bit 4:1 selector: steps the select through all four
// channels, captures the selector output per channel and hands the frame off.
module mux_scan_ctrl #(
  parameter int DIV      = 4,
  parameter int DATA_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  manual,
  input  logic [1:0]            man_sel,
  output logic [1:0]            Y,
  input  logic [DATA_LEN-1:0]   F,
  output logic [4*DATA_LEN-1:0] frame,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

  logic [1:0] state;
  logic [1:0] ch;
  logic [7:0] cnt;

  assign dbg_state = state;

  // Frame handshake: frame is held stable while frame_valid is high; the frame
  // is consumed on the rising edge where frame_valid && frame_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      Y           <= 2'd0;
      ch          <= 2'd0;
      cnt         <= 8'd0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            Y     <= 2'd0;
            ch    <= 2'd0;
            cnt   <= 8'd0;
            busy  <= 1'b1;
          end else begin
            Y <= manual ? man_sel : 2'd0;
          end
        end
        SCAN: begin
          if (cnt == CNT_LAST) begin
            // Y has been stable for DIV full cycles, so F has settled.
            cnt <= 8'd0;
            frame[int'(ch)*DATA_LEN +: DATA_LEN] <= F;
            if (ch == 2'd3) begin
              state       <= DONE;
              frame_valid <= 1'b1;
            end else begin
              ch <= ch + 2'd1;
              Y  <= ch + 2'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (frame_ready) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            Y           <= manual ? man_sel : 2'd0;
          end
        end
        default: begin
          state       <= IDLE;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
          Y           <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a DIV=4 instance driven through the main scenarios
// and a DIV=1 instance for single-cycle-per-channel scanning.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start, manual, frame_ready;
  logic [1:0] man_sel;
  logic [1:0] y;
  logic [1:0] f;
  logic [7:0] frame;
  logic       frame_valid, busy;
  logic [1:0] dbg_state;

  logic       start1, manual1, frame_ready1;
  logic [1:0] man_sel1;
  logic [1:0] y1;
  logic [1:0] f1;
  logic [7:0] frame1;
  logic       frame_valid1, busy1;
  logic [1:0] dbg_state1;

  logic [1:0] x_vals [4];
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int frames_seen = 0;

  assign f  = x_vals[y];
  assign f1 = x_vals[y1];

  mux_scan_ctrl #(.DIV(4), .DATA_LEN(2)) dut (
    .clk(clk), .rst(rst), .start(start), .manual(manual), .man_sel(man_sel),
    .Y(y), .F(f), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .dbg_state(dbg_state)
  );

  mux_scan_ctrl #(.DIV(1), .DATA_LEN(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .manual(manual1), .man_sel(man_sel1),
    .Y(y1), .F(f1), .frame(frame1), .frame_valid(frame_valid1),
    .frame_ready(frame_ready1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_exp();
    return {x_vals[3], x_vals[2], x_vals[1], x_vals[0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    exp_q.push_back(pack_exp());
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_valid(output int lat);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_valid) break;
    end
    if (!frame_valid) check("valid_timeout", {31'd0, frame_valid}, 32'd1);
    lat = cyc - start_cyc;
  endtask

  // scoreboard: compare each accepted frame against the queued expectation
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      frames_seen++;
      if (exp_q.size() == 0) check("spurious_frame", {31'd0, frame_valid}, 32'd0);
      else check("frame", {24'd0, frame}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int lat;
    int seen0;
    rst = 1'b1;
    start = 1'b0; manual = 1'b0; man_sel = 2'd0; frame_ready = 1'b1;
    start1 = 1'b0; manual1 = 1'b0; man_sel1 = 2'd0; frame_ready1 = 1'b1;
    x_vals[0] = 2'b01; x_vals[1] = 2'b10; x_vals[2] = 2'b11; x_vals[3] = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    check("rst_y", {30'd0, y}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame", {24'd0, frame}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // basic scan: Y walks 0..3, DIV cycles each
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("scan_y", {30'd0, y}, k / 4);
      check("scan_busy", {31'd0, busy}, 32'd1);
      check("scan_valid", {31'd0, frame_valid}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("done_valid", {31'd0, frame_valid}, 32'd1);
    check("done_latency", cyc - start_cyc, 32'd16);
    check("done_frame", {24'd0, frame}, 32'h39);
    tick();
    @(negedge clk);
    check("accept_busy", {31'd0, busy}, 32'd0);
    check("accept_y", {30'd0, y}, 32'd0);
    check("accept_valid", {31'd0, frame_valid}, 32'd0);
    tick();

    // backpressure in DONE
    frame_ready = 1'b0;
    seen0 = frames_seen;
    pulse_start();
    wait_valid(lat);
    check("bp_latency", lat, 32'd16);
    tick();
    x_vals[0] = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_frame", {24'd0, frame}, 32'h39);
      check("bp_valid", {31'd0, frame_valid}, 32'd1);
      check("bp_y", {30'd0, y}, 32'd3);
      tick();
    end
    frame_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_release_valid", {31'd0, frame_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("bp_single_accept", frames_seen - seen0, 32'd1);
    x_vals[0] = 2'b01;
    tick();

    // reset mid-scan
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (y == 2'd2) break;
      tick();
    end
    check("pre_rst_y", {30'd0, y}, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_y", {30'd0, y}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_frame", {24'd0, frame}, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_valid", {31'd0, frame_valid}, 32'd0);
      tick();
    end
    pulse_start();
    wait_valid(lat);
    check("post_rst_latency", lat, 32'd16);
    tick();
    tick();

    // start while busy, in SCAN and in DONE
    seen0 = frames_seen;
    frame_ready = 1'b0;
    pulse_start();
    repeat (5) tick();
    check("busy_start_y", {30'd0, y}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("busy_latency", lat, 32'd16);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    frame_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("busy_one_frame", frames_seen - seen0, 32'd1);
    tick();

    // manual select in IDLE
    manual = 1'b1;
    man_sel = 2'd2;
    @(negedge clk);
    check("man_y_before", {30'd0, y}, 32'd0);
    tick();
    @(negedge clk);
    check("man_y", {30'd0, y}, 32'd2);
    tick();
    pulse_start();
    @(negedge clk);
    check("man_start_y", {30'd0, y}, 32'd0);
    tick();
    man_sel = 2'd1;
    wait_valid(lat);
    check("man_latency", lat, 32'd16);
    tick();
    @(negedge clk);
    check("man_after_y", {30'd0, y}, 32'd1);
    check("man_after_busy", {31'd0, busy}, 32'd0);
    manual = 1'b0;
    tick();

    // DIV=1 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("div1_y", {30'd0, y1}, k);
      check("div1_valid_low", {31'd0, frame_valid1}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("div1_valid", {31'd0, frame_valid1}, 32'd1);
    check("div1_frame", {24'd0, frame1}, 32'h39);
    tick();
    @(negedge clk);
    check("div1_accept", {31'd0, busy1}, 32'd0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
